multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//  Sequencing FSM for the multi-cycle RV32I core: shares one memory port and one ALU across fetch,
//  decode, execute, memory and writeback steps. Drives datapath enables/selects each cycle, stalls
//  on a memory ready handshake and counts retired instructions. Feeds the existing alu_decoder via alu_op.
// PARAMETERS
//  INSTRET_W   32   width of retired-instruction counter (wraps modulo 2^INSTRET_W)
// PORTS
//  clk          in   1          core clock; all state updates on rising edge
//  reset        in   1          synchronous, active-high
//  op           in   7          instr[6:0] from instruction register
//  funct3       in   3          instr[14:12]
//  zero         in   1          ALU zero flag (combinational, current cycle)
//  mem_ready    in   1          memory completes the access presented this cycle
//  pc_write     out  1          PC register load enable
//  adr_src      out  1          mem address: 0=PC, 1=result
//  mem_write    out  1          memory write strobe, held until mem_ready
//  ir_write     out  1          instruction register + old_pc load enable
//  result_src   out  2          00=alu_out reg, 01=read data, 10=alu_result
//  alu_srcA     out  2          00=PC, 01=old_pc, 10=rd1
//  alu_srcB     out  2          00=rd2, 01=imm, 10=const 4
//  alu_op       out  2          00=add, 01=sub(branch), 10=funct-decoded
//  imm_src      out  3          000=I, 001=S, 010=B, 011=J; combinational from op, all states
//  reg_write    out  1          register file write enable
//  illegal_instr out 1          sticky illegal-opcode flag (see CONFIGURATION)
//  instret      out  INSTRET_W  retired-instruction count
// BEHAVIOUR
//  Reset: state=FETCH, instret=0, illegal_instr=0. Outputs are Moore decodes of state (except
//   pc_write/ir_write/state advance gated by mem_ready, branch pc_write gated by taken); strobes
//   not listed for a state are 0; unlisted selects are 00.
//  Reset mid-instruction: abandons it next edge; no write strobe asserted in the reset cycle.
//  FETCH: adr_src=0, srcA=00, srcB=10, alu_op=00, result_src=10; ir_write=pc_write=mem_ready.
//   Stay while !mem_ready; else -> DECODE.
//  DECODE: srcA=01, srcB=01, alu_op=00 (branch/jal target). Next by op:
//   0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1101111 -> JAL;
//   1100011 -> BRANCH; other -> illegal handling (CONFIGURATION).
//  MEMADR: srcA=10, srcB=01, alu_op=00 -> MEMREAD (op[5]=0) or MEMWRITE (op[5]=1).
//  MEMREAD: adr_src=1, result_src=00; stay while !mem_ready; else -> MEMWB.
//  MEMWB: result_src=01, reg_write=1 -> FETCH (retire).
//  MEMWRITE: adr_src=1, result_src=00, mem_write=1; stay while !mem_ready; else -> FETCH (retire).
//  EXECR: srcA=10, srcB=00, alu_op=10 -> ALUWB.  EXECI: srcA=10, srcB=01, alu_op=10 -> ALUWB.
//  ALUWB: result_src=00, reg_write=1 -> FETCH (retire).
//  JAL: srcA=01, srcB=10, alu_op=00, result_src=00, pc_write=1 -> ALUWB (rd=old_pc+4).
//  BRANCH: srcA=10, srcB=00, alu_op=01, result_src=00; taken = (funct3==000 & zero) |
//   (funct3==001 & ~zero); other funct3 never taken; pc_write=taken -> FETCH (retire).
//  Latency (mem_ready=1): R/I/JAL 4, lw 5, sw 4, branch 3 cycles; each stall cycle adds 1.
//  instret increments by 1 on the edge leaving a retire state; wraps all-ones -> 0.
//  mem_ready ignored outside FETCH/MEMREAD/MEMWRITE.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: unknown op in DECODE -> TRAP; TRAP drives all strobes 0, sets
//   illegal_instr=1, holds until reset; instret not incremented.
//  Not defined: unknown op in DECODE -> FETCH as a no-op (PC already +4), instret increments,
//   illegal_instr tied 0, no TRAP state.
// TESTING
//  add x3,x1,x2 (op=0110011), mem_ready=1 -> FETCH,DECODE,EXECR,ALUWB; reg_write only cycle 4; instret 0->1.
//  lw, mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, reg_write once in MEMWB, 8 cycles total.
//  sw, mem_ready low 2 cycles -> mem_write=1 for 3 consecutive cycles, adr_src=1, then FETCH.
//  beq zero=1 -> pc_write=1 in BRANCH; bne zero=1 -> pc_write=0; funct3=100 -> pc_write=0.
//  op=0000000 -> with ILLEGAL_TRAP_EN: illegal_instr=1, stays 10+ cycles, no strobes; without: back to FETCH, instret+1.
//  reset asserted in MEMWRITE -> next cycle FETCH, mem_write=0, instret=0; instret=all-ones + retire -> 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencing FSM: shared memory port/ALU control and retire counter.
// Build option: define ILLEGAL_TRAP_EN to trap (and flag) unknown opcodes instead of skipping them.
module multicycle_controller #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_srcA,
  output logic [1:0]           alu_srcB,
  output logic [1:0]           alu_op,
  output logic [2:0]           imm_src,
  output logic                 reg_write,
  output logic                 illegal_instr,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, JAL, BRANCH
`ifdef ILLEGAL_TRAP_EN
    , TRAP
`endif
  } state_t;

  state_t state, state_next;
  logic   retire;
  logic   taken;

  assign taken = (funct3 == 3'b000 &&  zero) ||
                 (funct3 == 3'b001 && !zero);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      instret <= '0;
    end else begin
      state <= state_next;
      if (retire) instret <= instret + INSTRET_W'(1);
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset)                   illegal_instr <= 1'b0;
    else if (state_next == TRAP) illegal_instr <= 1'b1;
  end
`else
  assign illegal_instr = 1'b0;
`endif

  always_comb begin
    state_next = state;
    retire     = 1'b0;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_srcA   = 2'b00;
    alu_srcB   = 2'b00;
    alu_op     = 2'b00;
    unique case (state)
      FETCH: begin
        alu_srcB   = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        alu_srcA = 2'b01;
        alu_srcB = 2'b01;
        unique case (op)
          7'b0000011,
          7'b0100011: state_next = MEMADR;
          7'b0110011: state_next = EXECR;
          7'b0010011: state_next = EXECI;
          7'b1101111: state_next = JAL;
          7'b1100011: state_next = BRANCH;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_next = TRAP;
`else
            state_next = FETCH;
            retire     = 1'b1;
`endif
          end
        endcase
      end
      MEMADR: begin
        alu_srcA   = 2'b10;
        alu_srcB   = 2'b01;
        state_next = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_next = FETCH;
        retire     = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          state_next = FETCH;
          retire     = 1'b1;
        end
      end
      EXECR: begin
        alu_srcA   = 2'b10;
        alu_op     = 2'b10;
        state_next = ALUWB;
      end
      EXECI: begin
        alu_srcA   = 2'b10;
        alu_srcB   = 2'b01;
        alu_op     = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        state_next = FETCH;
        retire     = 1'b1;
      end
      JAL: begin
        alu_srcA   = 2'b01;
        alu_srcB   = 2'b10;
        pc_write   = 1'b1;
        state_next = ALUWB;
      end
      BRANCH: begin
        alu_srcA   = 2'b10;
        alu_op     = 2'b01;
        pc_write   = taken;
        state_next = FETCH;
        retire     = 1'b1;
      end
      default: state_next = state;
    endcase
    // the instruction is abandoned: nothing may be written this cycle
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  always_comb begin
    unique case (op)
      7'b0100011: imm_src = 3'b001;
      7'b1100011: imm_src = 3'b010;
      7'b1101111: imm_src = 3'b011;
      default:    imm_src = 3'b000;
    endcase
  end

endmodule
